// File: rtl/pll_seq_ctrl.sv
// pll_seq_ctrl: PLL power-up/lock sequencer with runtime ODSEL/MDSEL reconfiguration and bounded relock.
// Define PLL_LOSS_CNT_EN to add loss_cnt_o, a saturating count of lock losses and lock timeouts.
module pll_seq_ctrl #(
  parameter int NUM_CH = 7,
  parameter int DIV_W = 7,
  parameter int MDIV_INIT = 50,
  parameter int ODIV0_INIT = 48,
  parameter int ODIVN_INIT = 8,
  parameter logic [NUM_CH-1:0] CH_EN_MASK = NUM_CH'(1),
  parameter int RST_CYCLES = 16,
  parameter int LOCK_FILT = 16,
  parameter int LOCK_TIMEOUT = 24000,
  parameter int GATE_CYCLES = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic pll_lock_i,
  input  logic cfg_req,
  input  logic cfg_mdiv,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic cfg_ack,
  output logic cfg_err,
  output logic pll_pwd_o,
  output logic pll_reset_o,
  output logic [DIV_W-1:0] pll_mdsel_o,
  output logic [NUM_CH*DIV_W-1:0] pll_odsel_o,
  output logic [NUM_CH-1:0] pll_enclk_o,
  output logic locked_o,
  output logic busy_o,
`ifdef PLL_LOSS_CNT_EN
  output logic [7:0] loss_cnt_o,
`endif
  output logic fault_o
);
  typedef enum logic [2:0] {PWRUP, RESET, WAIT_LOCK, RUN, GATE, APPLY, FAULT} state_t;
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(LOCK_TIMEOUT + RST_CYCLES + GATE_CYCLES + 1);
  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [CW-1:0] RST_END = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] GATE_END = CW'(GATE_CYCLES - 1);
  localparam logic [FW-1:0] FILT_END = FW'(LOCK_FILT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [FW-1:0] filt, filt_nx;
  logic [RW-1:0] retry, retry_nx;
  logic [1:0] sync;
  logic lock_s, md_pend, md_pend_nx, fail, acc_od, acc_md;
  logic [CHW-1:0] ch_q, ch_nx;
  logic [DIV_W-1:0] div_q, div_nx, mdsel_nx;
  logic [NUM_CH*DIV_W-1:0] odsel_nx;
  logic [NUM_CH-1:0] enclk_nx;
  logic pwd_nx, reset_nx, locked_nx, busy_nx, fault_nx, ack_nx, err_nx;
  assign lock_s = sync[1];
  assign acc_od = cfg_req && state == RUN && lock_s && !cfg_mdiv && int'(cfg_ch) < NUM_CH && cfg_div != '0;
  assign acc_md = cfg_req && state == RUN && lock_s && cfg_mdiv && cfg_div != '0;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt + 1'b1;
    filt_nx = filt;
    retry_nx = retry;
    md_pend_nx = md_pend;
    ch_nx = ch_q;
    div_nx = div_q;
    pwd_nx = pll_pwd_o;
    reset_nx = pll_reset_o;
    mdsel_nx = pll_mdsel_o;
    odsel_nx = pll_odsel_o;
    enclk_nx = pll_enclk_o;
    locked_nx = locked_o;
    fault_nx = fault_o;
    ack_nx = 1'b0;
    err_nx = cfg_req && !acc_od && !acc_md;
    fail = 1'b0;
    case (state)
      PWRUP: if (cnt == RST_END) begin
        state_nx = RESET;
        pwd_nx = 1'b0;
        cnt_nx = '0;
      end
      RESET: if (cnt == RST_END) begin
        state_nx = WAIT_LOCK;
        reset_nx = 1'b0;
        cnt_nx = '0;
        filt_nx = '0;
      end
      WAIT_LOCK: begin
        filt_nx = lock_s ? filt + 1'b1 : '0;
        if (lock_s && filt == FILT_END) begin
          state_nx = RUN;
          retry_nx = '0;
          enclk_nx = CH_EN_MASK;
          locked_nx = 1'b1;
          ack_nx = md_pend;
          md_pend_nx = 1'b0;
        end else if (cnt == TMO_END) fail = 1'b1;
      end
      RUN: if (!lock_s) fail = 1'b1;
      else if (acc_od) begin
        state_nx = GATE;
        ch_nx = cfg_ch;
        div_nx = cfg_div;
        enclk_nx[cfg_ch] = 1'b0;
        cnt_nx = '0;
      end else if (acc_md) begin
        state_nx = RESET;
        mdsel_nx = cfg_div;
        enclk_nx = '0;
        locked_nx = 1'b0;
        reset_nx = 1'b1;
        md_pend_nx = 1'b1;
        cnt_nx = '0;
      end
      GATE: if (!lock_s) begin
        fail = 1'b1;
        err_nx = 1'b1;
      end else if (cnt == GATE_END) begin
        state_nx = APPLY;
        odsel_nx[ch_q*DIV_W +: DIV_W] = div_q;
        cnt_nx = '0;
      end
      APPLY: if (!lock_s) begin
        fail = 1'b1;
        err_nx = 1'b1;
      end else if (cnt == GATE_END) begin
        state_nx = RUN;
        enclk_nx[ch_q] = CH_EN_MASK[ch_q];
        ack_nx = 1'b1;
      end
      default: ;
    endcase
    // Timeouts and lock losses share one retry budget; exhausting it parks the PLL in FAULT.
    if (fail) begin
      enclk_nx = '0;
      locked_nx = 1'b0;
      reset_nx = 1'b1;
      cnt_nx = '0;
      if (retry == RETRY_MAX) begin
        state_nx = FAULT;
        pwd_nx = 1'b1;
        fault_nx = 1'b1;
        err_nx = err_nx || md_pend;
        md_pend_nx = 1'b0;
      end else begin
        state_nx = RESET;
        retry_nx = retry + 1'b1;
      end
    end
    busy_nx = state_nx != RUN;
  end
  always_ff @(posedge clkin or negedge rst_n)
    if (!rst_n) begin
      state <= PWRUP;
      cnt <= '0;
      filt <= '0;
      retry <= '0;
      sync <= '0;
      md_pend <= 1'b0;
      ch_q <= '0;
      div_q <= '0;
      pll_pwd_o <= 1'b1;
      pll_reset_o <= 1'b1;
      pll_mdsel_o <= DIV_W'(MDIV_INIT);
      for (int k = 0; k < NUM_CH; k++) pll_odsel_o[k*DIV_W +: DIV_W] <= k == 0 ? DIV_W'(ODIV0_INIT) : DIV_W'(ODIVN_INIT);
      pll_enclk_o <= '0;
      locked_o <= 1'b0;
      busy_o <= 1'b1;
      fault_o <= 1'b0;
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      filt <= filt_nx;
      retry <= retry_nx;
      sync <= {sync[0], pll_lock_i};
      md_pend <= md_pend_nx;
      ch_q <= ch_nx;
      div_q <= div_nx;
      pll_pwd_o <= pwd_nx;
      pll_reset_o <= reset_nx;
      pll_mdsel_o <= mdsel_nx;
      pll_odsel_o <= odsel_nx;
      pll_enclk_o <= enclk_nx;
      locked_o <= locked_nx;
      busy_o <= busy_nx;
      fault_o <= fault_nx;
      cfg_ack <= ack_nx;
      cfg_err <= err_nx;
    end
`ifdef PLL_LOSS_CNT_EN
  always_ff @(posedge clkin or negedge rst_n)
    if (!rst_n) loss_cnt_o <= '0;
    else if (fail && loss_cnt_o != 8'hff) loss_cnt_o <= loss_cnt_o + 1'b1;
`endif
endmodule

// File: tb/tb_pll_seq_ctrl.sv
// tb_pll_seq_ctrl: directed bench for pll_seq_ctrl; request table plus power-up, MDSEL, lock-loss and fault sequences.
module tb_pll_seq_ctrl;
  localparam int NUM_CH = 7;
  localparam int DIV_W = 7;
  logic clkin = 0, rst_n = 0, pll_lock_i = 0, cfg_req = 0, cfg_mdiv = 0;
  logic [2:0] cfg_ch = '0;
  logic [6:0] cfg_div = '0;
  logic cfg_ack, cfg_err, pll_pwd_o, pll_reset_o, locked_o, busy_o, fault_o;
  logic [6:0] pll_mdsel_o, pll_enclk_o;
  logic [48:0] pll_odsel_o;
`ifdef PLL_LOSS_CNT_EN
  logic [7:0] loss_cnt_o;
`endif
  int n_cmp = 0, n_bad = 0, acks, errs, rh, rises;
  logic lk, prev;
  logic [6:0] eo [NUM_CH];
  logic [6:0] em;
  typedef struct {logic mdiv; logic [2:0] ch; logic [6:0] div; logic ok;} vec_t;
  vec_t vt [6];

  always #5 clkin = ~clkin;

  pll_seq_ctrl #(.LOCK_TIMEOUT(100)) dut (
    .clkin(clkin), .rst_n(rst_n), .pll_lock_i(pll_lock_i), .cfg_req(cfg_req), .cfg_mdiv(cfg_mdiv),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_ack(cfg_ack), .cfg_err(cfg_err), .pll_pwd_o(pll_pwd_o),
    .pll_reset_o(pll_reset_o), .pll_mdsel_o(pll_mdsel_o), .pll_odsel_o(pll_odsel_o),
    .pll_enclk_o(pll_enclk_o), .locked_o(locked_o), .busy_o(busy_o),
`ifdef PLL_LOSS_CNT_EN
    .loss_cnt_o(loss_cnt_o),
`endif
    .fault_o(fault_o));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [48:0] odsel_exp();
    logic [48:0] r;
    for (int k = 0; k < NUM_CH; k++) r[k*DIV_W +: DIV_W] = eo[k];
    return r;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clkin);
  endtask

  task automatic request(input logic md, input logic [2:0] ch, input logic [6:0] div);
    cfg_req = 1; cfg_mdiv = md; cfg_ch = ch; cfg_div = div;
    step();
    cfg_req = 0;
  endtask

  task automatic wait_run(input string name, input int lim);
    for (int i = 0; i < lim && busy_o; i++) step();
    check(name, busy_o, 0);
  endtask

  initial begin
    eo[0] = 48;
    for (int k = 1; k < NUM_CH; k++) eo[k] = 8;
    em = 50;
    vt[0] = '{1'b0, 3'd0, 7'd24, 1'b1};
    vt[1] = '{1'b0, 3'd3, 7'd5, 1'b1};
    vt[2] = '{1'b0, 3'd7, 7'd5, 1'b0};
    vt[3] = '{1'b0, 3'd2, 7'd0, 1'b0};
    vt[4] = '{1'b1, 3'd0, 7'd0, 1'b0};
    vt[5] = '{1'b0, 3'd6, 7'd127, 1'b1};

    step(3);
    check("rst_pwd", pll_pwd_o, 1);
    check("rst_reset", pll_reset_o, 1);
    check("rst_enclk", pll_enclk_o, 0);
    check("rst_mdsel", pll_mdsel_o, em);
    check("rst_odsel", pll_odsel_o, odsel_exp());
    check("rst_flags", {locked_o, busy_o, fault_o, cfg_ack, cfg_err}, 5'b01000);

    rst_n = 1;
    step(15);
    check("pwd_hold15", pll_pwd_o, 1);
    step();
    check("pwd_fall16", {pll_pwd_o, pll_reset_o}, 2'b01);
    step(15);
    check("reset_hold31", pll_reset_o, 1);
    step();
    check("reset_fall32", pll_reset_o, 0);
    pll_lock_i = 1;
    step(17);
    check("not_locked49", {locked_o, busy_o}, 2'b01);
    step();
    check("locked50", {locked_o, busy_o}, 2'b10);
    check("enclk_run", pll_enclk_o, 7'b0000001);

    foreach (vt[i]) begin
      acks = 0; errs = 0; lk = 1;
      request(vt[i].mdiv, vt[i].ch, vt[i].div);
      check($sformatf("v%0d_err_next", i), cfg_err, !vt[i].ok);
      for (int c = 0; c < 60; c++) begin
        acks += int'(cfg_ack);
        errs += int'(cfg_err);
        if (!locked_o) lk = 0;
        if (c == 4 && vt[i].ok) check($sformatf("v%0d_gated", i), pll_enclk_o[vt[i].ch], 0);
        step();
      end
      if (vt[i].ok) eo[vt[i].ch] = vt[i].div;
      check($sformatf("v%0d_acks", i), acks, vt[i].ok ? 1 : 0);
      check($sformatf("v%0d_errs", i), errs, vt[i].ok ? 0 : 1);
      check($sformatf("v%0d_locked", i), lk, 1);
      check($sformatf("v%0d_odsel", i), pll_odsel_o, odsel_exp());
      check($sformatf("v%0d_mdsel", i), pll_mdsel_o, em);
      check($sformatf("v%0d_enclk", i), pll_enclk_o, 7'b0000001);
    end

    acks = 0;
    request(0, 3'd1, 7'd9);
    step(2);
    request(0, 3'd2, 7'd3);
    check("gate_rej_err", cfg_err, 1);
    for (int c = 0; c < 40; c++) begin
      acks += int'(cfg_ack);
      step();
    end
    eo[1] = 9;
    check("gate_acks", acks, 1);
    check("gate_odsel", pll_odsel_o, odsel_exp());

    request(1, 3'd0, 7'd40);
    em = 40;
    check("md_enter", {pll_enclk_o, pll_reset_o, locked_o, busy_o}, {7'd0, 3'b101});
    check("md_mdsel", pll_mdsel_o, em);
    rh = 0;
    for (int c = 0; c < 40 && pll_reset_o; c++) begin
      rh++;
      step();
    end
    check("md_reset_len", rh, 16);
    for (int c = 0; c < 100 && !cfg_ack; c++) step();
    check("md_ack_run", {cfg_ack, busy_o, locked_o}, 3'b101);
    check("md_odsel", pll_odsel_o, odsel_exp());

    pll_lock_i = 0;
    step();
    pll_lock_i = 1;
    step();
    check("loss_not_early", locked_o, 1);
    step();
    check("loss_drop", {locked_o, pll_enclk_o}, 8'd0);
    wait_run("loss_relock", 100);
    check("loss_relocked", {locked_o, pll_enclk_o}, {1'b1, 7'b0000001});
`ifdef PLL_LOSS_CNT_EN
    check("loss_cnt1", loss_cnt_o, 1);
`endif

    pll_lock_i = 0;
    rises = 0; prev = pll_reset_o;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (fault_o) break;
      if (pll_reset_o && !prev) rises++;
      prev = pll_reset_o;
    end
    check("fault_set", fault_o, 1);
    check("fault_retries", rises, 3);
    check("fault_outs", {pll_pwd_o, pll_reset_o, pll_enclk_o, locked_o, busy_o}, {2'b11, 7'd0, 2'b01});
    request(0, 3'd0, 7'd5);
    check("fault_req_err", cfg_err, 1);
    step(5);
    check("fault_sticky", fault_o, 1);
    check("fault_odsel", pll_odsel_o, odsel_exp());
`ifdef PLL_LOSS_CNT_EN
    check("loss_cnt5", loss_cnt_o, 5);
`endif

    #2 rst_n = 0;
    #1;
    eo[0] = 48;
    for (int k = 1; k < NUM_CH; k++) eo[k] = 8;
    check("arst_flags", {fault_o, pll_pwd_o, pll_reset_o, locked_o, busy_o}, 5'b01101);
    check("arst_mdsel", pll_mdsel_o, 50);
    check("arst_odsel", pll_odsel_o, odsel_exp());
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
